alien_swarm_controller: RTL and testbench

- Parametrised successor to the single-alien controller: manages NUM_ALIENS independent aliens from one shared step timer and one shared LFSR.
- Per alien: spawn at the right edge with random Y, random-walk leftward, clamp inside the playfield, retire on hit or escape, respawn after a delay.
- Sits between the hit-detection logic (per-alien hit vector in) and the sprite renderer and score logic (positions, active flags and event pulses out).

---
 rtl/alien_pkg.sv | 26 ++
 rtl/alien_slot.sv | 119 +++++++++++
 rtl/alien_swarm_controller.sv | 106 ++++++++++
 tb/tb_alien_swarm_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_pkg.sv
// Shared types and constants for the alien swarm controller and its per-slot logic.
// Also holds the LFSR step function used for spawn Y and walk directions.
package alien_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HIT
    } slot_state_e;

    // Walk direction codes; every other code is a plain left move.
    localparam logic [2:0] DIR_UP        = 3'd2;
    localparam logic [2:0] DIR_DOWN      = 3'd3;
    localparam logic [2:0] DIR_LEFT_UP   = 3'd4;
    localparam logic [2:0] DIR_LEFT_DOWN = 3'd5;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;  // taps 16,14,13,11

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/alien_slot.sv
// One alien slot: IDLE/ACTIVE/HIT state machine, position registers and respawn countdown.
// Spawn selection and the step strobe come from the swarm controller.
module alien_slot
    import alien_pkg::*;
#(
    parameter int START_X       = 673,
    parameter int X_MIN         = 153,
    parameter int Y_MIN         = 65,
    parameter int Y_MAX         = 485,
    parameter int RESPAWN_STEPS = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               step_tick,
    input  logic               hit,
    input  logic               spawn,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic [2:0]         dir,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               kill_pulse,
    output logic               escape_pulse,
    output logic               ready,
    output logic               in_hit
);

    localparam int RESP_W = (RESPAWN_STEPS > 0) ? $clog2(RESPAWN_STEPS + 1) : 1;

    slot_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [RESP_W-1:0]  resp_q, resp_d;
    logic               active_q, active_d;
    logic               kill_q, kill_d;
    logic               esc_q, esc_d;
    logic               move_left, move_up, move_down;

    always_comb begin
        move_left = !(dir == DIR_UP || dir == DIR_DOWN);
        move_up   = (dir == DIR_UP) || (dir == DIR_LEFT_UP);
        move_down = (dir == DIR_DOWN) || (dir == DIR_LEFT_DOWN);

        // NOTE: every _d gets a hold/default value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        resp_d   = resp_q;
        active_d = active_q;
        kill_d   = 1'b0;
        esc_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (spawn) begin
                    state_d  = ACTIVE;
                    x_d      = COORD_W'(START_X);
                    y_d      = spawn_y;
                    active_d = 1'b1;
                end else if (step_tick && resp_q != '0) begin
                    resp_d = resp_q - RESP_W'(1);
                end
            end
            ACTIVE: begin
                if (hit) begin
                    state_d  = HIT;
                    active_d = 1'b0;
                end else if (step_tick) begin
                    if (move_left && x_q == COORD_W'(X_MIN)) begin
                        // Walking off the left edge: retire in place and wait to respawn.
                        state_d  = IDLE;
                        active_d = 1'b0;
                        esc_d    = 1'b1;
                        resp_d   = RESP_W'(RESPAWN_STEPS);
                    end else begin
                        if (move_left) x_d = x_q - COORD_W'(1);
                        if (move_up && y_q > COORD_W'(Y_MIN)) y_d = y_q - COORD_W'(1);
                        if (move_down && y_q < COORD_W'(Y_MAX)) y_d = y_q + COORD_W'(1);
                    end
                end
            end
            HIT: begin
                kill_d  = 1'b1;
                resp_d  = RESP_W'(RESPAWN_STEPS);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x_q      <= COORD_W'(START_X);
            y_q      <= COORD_W'(Y_MIN);
            resp_q   <= '0;
            active_q <= 1'b0;
            kill_q   <= 1'b0;
            esc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            resp_q   <= resp_d;
            active_q <= active_d;
            kill_q   <= kill_d;
            esc_q    <= esc_d;
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign active       = active_q;
    assign kill_pulse   = kill_q;
    assign escape_pulse = esc_q;
    assign ready        = (state_q == IDLE) && (resp_q == '0);
    assign in_hit       = (state_q == HIT);

endmodule

// File: rtl/alien_swarm_controller.sv
// Swarm top: shared step timer and LFSR, lowest-index spawn arbitration with Y rejection
// sampling, saturating kill counter, and NUM_ALIENS alien_slot instances.
module alien_swarm_controller
    import alien_pkg::*;
#(
    parameter int          NUM_ALIENS    = 4,
    parameter int          START_X       = 673,
    parameter int          X_MIN         = 153,
    parameter int          Y_MIN         = 65,
    parameter int          Y_MAX         = 485,
    parameter int          STEP_TICKS    = 500000,
    parameter int          RESPAWN_STEPS = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [NUM_ALIENS-1:0]         hit_vec,
    output logic [COORD_W*NUM_ALIENS-1:0] alien_x,
    output logic [COORD_W*NUM_ALIENS-1:0] alien_y,
    output logic [NUM_ALIENS-1:0]         alien_active,
    output logic [NUM_ALIENS-1:0]         kill_pulse,
    output logic [NUM_ALIENS-1:0]         escape_pulse,
    output logic [15:0]                   kill_count
);

    localparam int          STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0) ? LFSR_DEFAULT_SEED : LFSR_SEED;

    logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
    logic                  step_tick;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [15:0]           kill_count_q, kill_count_d;
    logic [16:0]           kill_sum;
    logic [COORD_W-1:0]    cand_y;
    logic                  spawn_found;
    logic [NUM_ALIENS-1:0] ready, in_hit, spawn;

    always_comb begin
        step_tick  = enable && (step_cnt_q == STEP_W'(STEP_TICKS - 1));
        step_cnt_d = step_cnt_q;
        if (enable) step_cnt_d = step_tick ? '0 : step_cnt_q + STEP_W'(1);
        lfsr_d = lfsr_next(lfsr_q);
    end

    // Out-of-range candidates spawn nobody; the LFSR offers a fresh one next cycle.
    always_comb begin
        cand_y      = COORD_W'(Y_MIN) + COORD_W'(lfsr_q[8:0]);
        spawn       = '0;
        spawn_found = 1'b0;
        if (enable && cand_y <= COORD_W'(Y_MAX)) begin
            for (int i = 0; i < NUM_ALIENS; i++) begin
                if (!spawn_found && ready[i]) begin
                    spawn[i]    = 1'b1;
                    spawn_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        kill_sum = {1'b0, kill_count_q};
        for (int i = 0; i < NUM_ALIENS; i++) kill_sum = kill_sum + 17'(in_hit[i]);
        kill_count_d = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt_q   <= '0;
            lfsr_q       <= SEED;
            kill_count_q <= '0;
        end else begin
            step_cnt_q   <= step_cnt_d;
            lfsr_q       <= lfsr_d;
            kill_count_q <= kill_count_d;
        end
    end

    assign kill_count = kill_count_q;

    for (genvar i = 0; i < NUM_ALIENS; i++) begin : g_slot
        alien_slot #(
            .START_X      (START_X),
            .X_MIN        (X_MIN),
            .Y_MIN        (Y_MIN),
            .Y_MAX        (Y_MAX),
            .RESPAWN_STEPS(RESPAWN_STEPS)
        ) u_slot (
            .clk         (clk),
            .reset_n     (reset_n),
            .step_tick   (step_tick),
            .hit         (hit_vec[i]),
            .spawn       (spawn[i]),
            .spawn_y     (cand_y),
            .dir         (lfsr_q[(3*i)%14 +: 3]),
            .x           (alien_x[COORD_W*i +: COORD_W]),
            .y           (alien_y[COORD_W*i +: COORD_W]),
            .active      (alien_active[i]),
            .kill_pulse  (kill_pulse[i]),
            .escape_pulse(escape_pulse[i]),
            .ready       (ready[i]),
            .in_hit      (in_hit[i])
        );
    end

endmodule

// File: tb/tb_alien_swarm_controller.sv
// Self-checking bench: two-slot swarm with short step/respawn times, a cycle model of the
// behaviour, a direction/clamp vector table, and hand-written hit, saturation and reset sequences.
module tb_alien_swarm_controller;

    localparam int ST   = 4;
    localparam int RS   = 2;
    localparam int SX   = 20;
    localparam int XM   = 16;
    localparam int YMIN = 65;
    localparam int YMAX = 485;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic [1:0]  hit_vec = 2'b00;
    logic [19:0] alien_x, alien_y;
    logic [1:0]  alien_active, kill_pulse, escape_pulse;
    logic [15:0] kill_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alien_swarm_controller #(
        .NUM_ALIENS   (2),
        .START_X      (SX),
        .X_MIN        (XM),
        .Y_MIN        (YMIN),
        .Y_MAX        (YMAX),
        .STEP_TICKS   (ST),
        .RESPAWN_STEPS(RS),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .hit_vec     (hit_vec),
        .alien_x     (alien_x),
        .alien_y     (alien_y),
        .alien_active(alien_active),
        .kill_pulse  (kill_pulse),
        .escape_pulse(escape_pulse),
        .kill_count  (kill_count)
    );

    // Reference model state (0 = IDLE, 1 = ACTIVE, 2 = HIT)
    logic [15:0] m_lfsr;
    int          m_cnt, m_kc;
    int          m_state[2], m_resp[2], m_x[2], m_y[2];
    logic [1:0]  m_act, m_kp, m_ep;
    logic [15:0] force_val;

    typedef struct {
        logic [15:0] lfsr;
        int          x;
        int          y;
        logic        act;
        logic        esc;
    } dir_vec_t;
    dir_vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_cnt  = 0;
        m_kc   = 0;
        m_act  = 2'b00;
        m_kp   = 2'b00;
        m_ep   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_resp[i]  = 0;
            m_x[i]     = SX;
            m_y[i]     = YMIN;
        end
    endtask

    task automatic model_step();
        logic tick, left, up, down, spawned;
        int   cand, dir, n_hit;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tick    = enable && (m_cnt == ST - 1);
        cand    = YMIN + int'(m_lfsr[8:0]);
        spawned = 1'b0;
        n_hit   = 0;
        m_kp    = 2'b00;
        m_ep    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            case (m_state[i])
                0: begin
                    if (m_resp[i] == 0 && enable && cand <= YMAX && !spawned) begin
                        spawned    = 1'b1;
                        m_state[i] = 1;
                        m_x[i]     = SX;
                        m_y[i]     = cand;
                        m_act[i]   = 1'b1;
                    end else if (tick && m_resp[i] > 0) begin
                        m_resp[i]--;
                    end
                end
                1: begin
                    if (hit_vec[i]) begin
                        m_state[i] = 2;
                        m_act[i]   = 1'b0;
                    end else if (tick) begin
                        dir  = int'((m_lfsr >> ((3 * i) % 14)) & 16'h7);
                        left = !(dir == 2 || dir == 3);
                        up   = (dir == 2 || dir == 4);
                        down = (dir == 3 || dir == 5);
                        if (left && m_x[i] == XM) begin
                            m_act[i]   = 1'b0;
                            m_ep[i]    = 1'b1;
                            m_resp[i]  = RS;
                            m_state[i] = 0;
                        end else begin
                            if (left) m_x[i]--;
                            if (up && m_y[i] > YMIN) m_y[i]--;
                            if (down && m_y[i] < YMAX) m_y[i]++;
                        end
                    end
                end
                default: begin
                    m_kp[i]    = 1'b1;
                    n_hit++;
                    m_resp[i]  = RS;
                    m_state[i] = 0;
                end
            endcase
        end
        m_kc   = (m_kc + n_hit > 65535) ? 65535 : m_kc + n_hit;
        m_cnt  = !enable ? m_cnt : (tick ? 0 : m_cnt + 1);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic compare_all();
        logic [19:0] ex, ey;
        ex = {10'(m_x[1]), 10'(m_x[0])};
        ey = {10'(m_y[1]), 10'(m_y[0])};
        check("lockstep", {2'b00, alien_x, alien_y, alien_active, kill_pulse, escape_pulse, kill_count},
              {2'b00, ex, ey, m_act, m_kp, m_ep, 16'(m_kc)});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_lfsr(input logic [15:0] v);
        force_val = v;
        force dut.lfsr_q = force_val;
        m_lfsr = v;
        #1;
        release dut.lfsr_q;
    endtask

    task automatic wait_tick_next();
        for (int k = 0; k < ST + 1 && !(enable && m_cnt == ST - 1); k++) cycle();
    endtask

    task automatic wait_active(input logic [1:0] mask, input string name);
        for (int k = 0; k < 100 && ((alien_active & mask) != mask); k++) cycle();
        check(name, alien_active & mask, mask);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_x"}, alien_x, {10'd20, 10'd20});
        check({name, "_y"}, alien_y, {10'd65, 10'd65});
        check({name, "_active"}, alien_active, 2'b00);
        check({name, "_kill_pulse"}, kill_pulse, 2'b00);
        check({name, "_escape_pulse"}, escape_pulse, 2'b00);
        check({name, "_kill_count"}, kill_count, 16'h0000);
    endtask

    task automatic async_reset(input string name);
        @(posedge clk);
        model_step();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_vals(name);
        @(negedge clk);
        compare_all();
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        first_seen, both_seen, esc_checked;
        int          esc_cnt, min_x, xi;
        logic [19:0] sx, sy;

        // Direction / clamp vectors for slot 0 starting at (20,65); dir = lfsr[2:0].
        tbl[0] = '{16'h8002, 20, 65, 1'b1, 1'b0};  // up, clamped at Y_MIN
        tbl[1] = '{16'h8004, 19, 65, 1'b1, 1'b0};  // left+up, y clamped, x moves
        tbl[2] = '{16'h8003, 19, 66, 1'b1, 1'b0};  // down
        tbl[3] = '{16'h8005, 18, 67, 1'b1, 1'b0};  // left+down
        tbl[4] = '{16'h8002, 18, 66, 1'b1, 1'b0};  // up
        tbl[5] = '{16'h8000, 17, 66, 1'b1, 1'b0};  // left
        tbl[6] = '{16'h8007, 16, 66, 1'b1, 1'b0};  // left, reaches X_MIN
        tbl[7] = '{16'h8003, 16, 67, 1'b1, 1'b0};  // down at X_MIN, no escape
        tbl[8] = '{16'h8006, 16, 67, 1'b0, 1'b1};  // left at X_MIN: escape, position held

        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");

        // Release reset: first spawns, free run with escapes and respawns.
        reset_n     = 1'b1;
        enable      = 1'b1;
        first_seen  = 1'b0;
        both_seen   = 1'b0;
        esc_checked = 1'b0;
        esc_cnt     = 0;
        min_x       = 1023;
        for (int c = 0; c < 160; c++) begin
            cycle();
            if (!first_seen && alien_active != 2'b00) begin
                first_seen = 1'b1;
                check("first_spawn_active", alien_active, 2'b01);
                check("first_spawn_x", alien_x[9:0], 10'd20);
                check("first_spawn_y_range", (alien_y[9:0] >= 10'd65) && (alien_y[9:0] <= 10'd485), 1'b1);
            end
            if (alien_active == 2'b11) both_seen = 1'b1;
            for (int i = 0; i < 2; i++) begin
                xi = int'(alien_x[10*i +: 10]);
                if (alien_active[i] && xi < min_x) min_x = xi;
                if (escape_pulse[i]) begin
                    esc_cnt++;
                    if (!esc_checked) begin
                        esc_checked = 1'b1;
                        check("escape_drops_active", alien_active[i], 1'b0);
                        check("escape_at_x_min", alien_x[10*i +: 10], 10'd16);
                    end
                end
            end
        end
        check("both_spawned", both_seen, 1'b1);
        check("escape_seen", esc_cnt > 0, 1'b1);
        check("x_floor", min_x >= 16, 1'b1);

        // Direction table including Y clamp at Y_MIN and the escape at X_MIN.
        async_reset("async_reset_a");
        reset_n = 1'b1;
        set_lfsr(16'h8000);
        cycle();
        check("clamp_spawn_y", alien_y[9:0], 10'd65);
        check("clamp_spawn_x", alien_x[9:0], 10'd20);
        for (int e = 0; e < 9; e++) begin
            wait_tick_next();
            set_lfsr(tbl[e].lfsr);
            cycle();
            check($sformatf("dir%0d_x", e), alien_x[9:0], 64'(tbl[e].x));
            check($sformatf("dir%0d_y", e), alien_y[9:0], 64'(tbl[e].y));
            check($sformatf("dir%0d_active", e), alien_active[0], tbl[e].act);
            check($sformatf("dir%0d_escape", e), escape_pulse[0], tbl[e].esc);
        end

        // Simultaneous hit on a step tick.
        async_reset("async_reset_b");
        reset_n = 1'b1;
        wait_active(2'b11, "both_active_for_hit");
        wait_tick_next();
        sx      = {10'(m_x[1]), 10'(m_x[0])};
        sy      = {10'(m_y[1]), 10'(m_y[0])};
        hit_vec = 2'b11;
        cycle();
        hit_vec = 2'b00;
        check("hit_active_cleared", alien_active, 2'b00);
        check("hit_x_not_moved", alien_x, sx);
        check("hit_y_not_moved", alien_y, sy);
        check("hit_no_pulse_yet", kill_pulse, 2'b00);
        cycle();
        check("hit_kill_pulse", kill_pulse, 2'b11);
        check("hit_kill_count", kill_count, 16'd2);
        cycle();
        check("hit_kill_pulse_single", kill_pulse, 2'b00);

        // Saturation from a preloaded count.
        force_val = 16'hFFFE;
        force dut.kill_count_q = force_val;
        m_kc = 65534;
        #1;
        release dut.kill_count_q;
        wait_active(2'b11, "both_active_for_sat");
        hit_vec = 2'b11;
        cycle();
        hit_vec = 2'b00;
        cycle();
        check("sat_kill_count", kill_count, 16'hFFFF);
        cycle();
        check("sat_kill_count_hold", kill_count, 16'hFFFF);

        // Freeze with enable low; hits still processed.
        wait_active(2'b11, "both_active_for_freeze");
        enable = 1'b0;
        sx     = {10'(m_x[1]), 10'(m_x[0])};
        sy     = {10'(m_y[1]), 10'(m_y[0])};
        repeat (10) cycle();
        check("freeze_x", alien_x, sx);
        check("freeze_y", alien_y, sy);
        hit_vec = 2'b01;
        cycle();
        hit_vec = 2'b00;
        check("freeze_hit_active", alien_active, 2'b10);
        cycle();
        check("freeze_hit_pulse", kill_pulse, 2'b01);
        repeat (8) cycle();
        check("freeze_x_end", alien_x, sx);
        check("freeze_y_end", alien_y, sy);
        check("freeze_no_respawn", alien_active, 2'b10);

        // Asynchronous reset mid-step.
        async_reset("async_reset_c");
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
